conv_scheduler: RTL and testbench



---
 rtl/bnn_pkg.sv | 54 +++++
 rtl/bnn_credit_counter.sv | 56 +++++
 rtl/conv_scheduler.sv | 147 ++++++++++++++
 tb/tb_conv_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bnn_pkg
// Brief   : Shared constants, scheduler states and window descriptor type.
// Rev     : 1.0
// ============================================================================
package bnn_pkg;

    localparam int IMG_DIM  = 28;
    localparam int K        = 3;
    localparam int N_FILT   = 8;
    localparam int OUT_DIM  = IMG_DIM - K + 1;
    localparam int CREDIT_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [4:0] row;
        logic [4:0] col;
        logic [2:0] filt;
        logic       last;
    } win_desc_t;

    // Filter innermost, then column, then row; last flags the final window.
    function automatic win_desc_t next_desc(
        input win_desc_t  d,
        input logic [4:0] pos_max,
        input logic [2:0] filt_max
    );
        win_desc_t n;
        n = d;
        if (d.filt == filt_max) begin
            n.filt = '0;
            if (d.col == pos_max) begin
                n.col = '0;
                n.row = d.row + 5'd1;
            end else begin
                n.col = d.col + 5'd1;
            end
        end else begin
            n.filt = d.filt + 3'd1;
        end
        n.last = (n.row == pos_max) && (n.col == pos_max) && (n.filt == filt_max);
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_credit_counter.sv
`default_nettype none
// ============================================================================
// Module  : bnn_credit_counter
// Brief   : Windows-in-flight counter; full looks ahead to the post-edge count.
// Rev     : 1.0
// ============================================================================
module bnn_credit_counter
    import bnn_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                inc,
    input  logic                dec,
    output logic [CREDIT_W-1:0] count,
    output logic                full,
    output logic                underflow
);

    localparam logic [CREDIT_W-1:0] c_max = CREDIT_W'(MAX_OUT);
    localparam logic [CREDIT_W-1:0] c_one = CREDIT_W'(1);

    logic [CREDIT_W-1:0] r_count;
    logic [CREDIT_W-1:0] w_count_next;
    logic                w_dec_ok;

    // A retire against an empty counter is dropped; the caller flags it.
    assign w_dec_ok = dec && (r_count != '0);

    always_comb begin
        w_count_next = r_count;
        if (clear) begin
            w_count_next = '0;
        end else if (inc && !w_dec_ok) begin
            w_count_next = r_count + c_one;
        end else if (!inc && w_dec_ok) begin
            w_count_next = r_count - c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count     = r_count;
    assign full      = (w_count_next >= c_max);
    assign underflow = dec && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : conv_scheduler
// Brief   : Load, then issue every (row, col, filter) window under credit control.
// Rev     : 1.0
// ============================================================================
module conv_scheduler #(
    parameter int IMG_DIM = bnn_pkg::IMG_DIM,
    parameter int K       = bnn_pkg::K,
    parameter int N_FILT  = bnn_pkg::N_FILT,
    parameter int MAX_OUT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       en_wr,
    input  logic       load_done,
    output logic       win_valid,
    input  logic       win_ready,
    output logic [4:0] win_row,
    output logic [4:0] win_col,
    output logic [2:0] win_filt,
    output logic       win_last,
    input  logic       res_valid,
    output logic       busy,
    output logic       done,
    output logic       err
);

    import bnn_pkg::sched_state_t;
    import bnn_pkg::win_desc_t;
    import bnn_pkg::next_desc;
    import bnn_pkg::CREDIT_W;

    localparam logic [4:0]          c_pos_max    = 5'(IMG_DIM - K);
    localparam logic [2:0]          c_filt_max   = 3'(N_FILT - 1);
    localparam logic                c_first_last = (c_pos_max == 5'd0) && (c_filt_max == 3'd0);
    localparam logic [CREDIT_W-1:0] c_one        = CREDIT_W'(1);

    sched_state_t        r_state;
    win_desc_t           r_desc;
    logic                r_win_valid;
    logic                r_en_wr;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_xfer;
    logic                w_start_ok;
    logic                w_full;
    logic                w_underflow;
    logic                w_drained;
    logic [CREDIT_W-1:0] w_credits;
    win_desc_t           w_next_desc;

    assign w_xfer      = r_win_valid && win_ready;
    assign w_start_ok  = start && (r_state == bnn_pkg::IDLE || r_state == bnn_pkg::DONE);
    assign w_next_desc = next_desc(r_desc, c_pos_max, c_filt_max);
    // Nothing is issued in DRAIN, so the count reaches zero this edge or already sits there.
    assign w_drained   = (w_credits == '0 && !res_valid) || (w_credits == c_one && res_valid);

    bnn_credit_counter #(
        .MAX_OUT (MAX_OUT)
    ) u_credits (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (w_start_ok),
        .inc       (w_xfer),
        .dec       (res_valid),
        .count     (w_credits),
        .full      (w_full),
        .underflow (w_underflow)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= bnn_pkg::IDLE;
            r_desc      <= '0;
            r_win_valid <= 1'b0;
            r_en_wr     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (res_valid && (r_state == bnn_pkg::IDLE || r_state == bnn_pkg::LOAD || w_underflow)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                bnn_pkg::IDLE, bnn_pkg::DONE: begin
                    if (start) begin
                        r_state <= bnn_pkg::LOAD;
                        r_en_wr <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_desc  <= '{row: 5'd0, col: 5'd0, filt: 3'd0, last: c_first_last};
                    end
                end
                bnn_pkg::LOAD: begin
                    if (load_done) begin
                        r_state     <= bnn_pkg::ISSUE;
                        r_en_wr     <= 1'b0;
                        r_win_valid <= !w_full;
                    end
                end
                bnn_pkg::ISSUE: begin
                    if (w_xfer && r_desc.last) begin
                        r_state     <= bnn_pkg::DRAIN;
                        r_win_valid <= 1'b0;
                    end else begin
                        if (w_xfer) begin
                            r_desc <= w_next_desc;
                        end
                        // Credits never rise without a transfer, so a held descriptor stays valid.
                        r_win_valid <= !w_full;
                    end
                end
                bnn_pkg::DRAIN: begin
                    if (w_drained) begin
                        r_state <= bnn_pkg::DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= bnn_pkg::IDLE;
                    r_win_valid <= 1'b0;
                    r_en_wr     <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign en_wr     = r_en_wr;
    assign win_valid = r_win_valid;
    assign win_row   = r_desc.row;
    assign win_col   = r_desc.col;
    assign win_filt  = r_desc.filt;
    assign win_last  = r_desc.last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_scheduler.sv
`default_nettype none
// tb_conv_scheduler: directed and randomized run of conv_scheduler against an
// index-arithmetic reference for window order, credit limit and completion.
module tb_conv_scheduler;

    localparam int MAXO  = 4;
    localparam int OUTD  = 26;
    localparam int NF    = 8;
    localparam int TOTAL = OUTD * OUTD * NF;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       en_wr;
    logic       load_done;
    logic       win_valid;
    logic       win_ready;
    logic [4:0] win_row;
    logic [4:0] win_col;
    logic [2:0] win_filt;
    logic       win_last;
    logic       res_valid;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;
    int sent  = 0;
    int outst = 0;
    bit issuing   = 1'b0;
    bit last_xfer = 1'b0;

    conv_scheduler #(
        .IMG_DIM (28),
        .K       (3),
        .N_FILT  (8),
        .MAX_OUT (MAXO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .en_wr     (en_wr),
        .load_done (load_done),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_row   (win_row),
        .win_col   (win_col),
        .win_filt  (win_filt),
        .win_last  (win_last),
        .res_valid (res_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] exp_desc(input int idx);
        logic [4:0] r;
        logic [4:0] c;
        logic [2:0] f;
        r = 5'(idx / (OUTD * NF));
        c = 5'((idx / NF) % OUTD);
        f = 3'(idx % NF);
        return {r, c, f, (idx == TOTAL - 1)};
    endfunction

    function automatic logic [13:0] cur_desc();
        return {win_row, win_col, win_filt, win_last};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_en_wr"},     32'(en_wr),      0);
        check({tag, "_win_valid"}, 32'(win_valid),  0);
        check({tag, "_win_last"},  32'(win_last),   0);
        check({tag, "_busy"},      32'(busy),       0);
        check({tag, "_done"},      32'(done),       0);
        check({tag, "_err"},       32'(err),        0);
        check({tag, "_desc"},      32'(cur_desc()), 0);
    endtask

    // One cycle of handshake traffic, checked against the reference model.
    task automatic step(input bit rdy, input bit res);
        logic        v;
        logic [13:0] d;
        bit          x;
        win_ready = rdy;
        res_valid = res;
        v = win_valid;
        d = cur_desc();
        x = v && rdy;
        if (x) begin
            check("desc_order", 32'(d), 32'(exp_desc(sent)));
            sent++;
        end
        tick();
        outst     = outst + (x ? 1 : 0) - (res ? 1 : 0);
        last_xfer = x;
        if (v && !rdy) begin
            check("stall_valid", 32'(win_valid), 1);
            check("stall_desc",  32'(cur_desc()), 32'(d));
        end
        check("valid_rule", 32'(win_valid), 32'(issuing && outst < MAXO && sent < TOTAL));
        check("done_rule",  32'(done),      32'(issuing && sent == TOTAL && outst == 0));
        check("busy_rule",  32'(busy),      32'(issuing && !(sent == TOTAL && outst == 0)));
        check("en_wr_low",  32'(en_wr),     0);
    endtask

    task automatic begin_issue();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        sent      = 0;
        outst     = 0;
        last_xfer = 1'b0;
        issuing   = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        load_done = 1'b0;
        win_ready = 1'b0;
        res_valid = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Start and hold the load phase.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_en_wr", 32'(en_wr), 1);
        check("load_busy",  32'(busy),  1);
        for (int i = 0; i < 100; i++) begin
            start = (i == 50);
            tick();
            check("load_hold_en_wr", 32'(en_wr),     1);
            check("load_hold_valid", 32'(win_valid), 0);
        end
        start = 1'b0;
        begin_issue();
        check("issue_en_wr",  32'(en_wr),      0);
        check("first_valid",  32'(win_valid),  1);
        check("first_desc",   32'(cur_desc()), 32'(exp_desc(0)));

        // Full pass: always ready, each result one cycle after its transfer.
        for (int i = 0; i < TOTAL + 200 && !(sent == TOTAL && outst == 0); i++) begin
            start = (i == 100);
            step(1'b1, last_xfer);
        end
        start = 1'b0;
        check("run1_transfers", 32'(sent),  TOTAL);
        check("run1_done",      32'(done),  1);
        check("run1_busy",      32'(busy),  0);
        check("run1_err",       32'(err),   0);
        repeat (3) tick();
        check("done_holds",     32'(done),  1);

        // Restart from DONE; withhold results to hit the credit limit.
        issuing = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done_clr", 32'(done),  0);
        check("restart_en_wr",    32'(en_wr), 1);
        tick();
        begin_issue();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        check("credit_limit_sent",  32'(sent),      MAXO);
        check("credit_limit_valid", 32'(win_valid), 0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("one_credit_one_more", 32'(sent), MAXO + 1);

        // Random stalls and random result timing to completion.
        for (int i = 0; i < 40000 && !(sent == TOTAL && outst == 0); i++) begin
            step(($urandom_range(0, 3) != 0), (outst > 0) && ($urandom_range(0, 3) != 0));
        end
        check("run2_transfers", 32'(sent), TOTAL);
        check("run2_done",      32'(done), 1);

        // Underflow error, then reset in the middle of ISSUE.
        issuing = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        begin_issue();
        win_ready = 1'b0;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        check("underflow_err",   32'(err),       1);
        check("underflow_valid", 32'(win_valid), 1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        check("underflow_credits_zero", 32'(sent), MAXO);
        for (int i = 0; i < 4000 && sent < 2109; i++) step(1'b1, (outst > 0));
        check("mid_desc",  32'(cur_desc()), 32'({5'd10, 5'd3, 3'd5, 1'b0}));
        check("mid_valid", 32'(win_valid),  1);
        reset_n   = 1'b0;
        win_ready = 1'b1;
        tick();
        win_ready = 1'b0;
        check_reset_values("mid_reset");
        reset_n = 1'b1;
        issuing = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_en_wr", 32'(en_wr), 1);
        begin_issue();
        check("rerun_first_desc", 32'(cur_desc()), 32'(exp_desc(0)));
        check("rerun_valid",      32'(win_valid),  1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        check("rerun_credits_clear", 32'(sent), MAXO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
